// File: rtl/line_clear_unit.sv
// Merges a landed piece into the 12x12 playfield, then scans bottom-up and
// collapses every full row, reporting the number of rows removed and top-out.
module line_clear_unit (
    input  logic         clk,
    input  logic         reset,
    input  logic         lock,
    input  logic [144:0] currentSqs,
    output logic [144:0] backGround,
    output logic         busy,
    output logic         done,
    output logic [3:0]   lines_cleared,
    output logic         game_over
);

    typedef enum logic [1:0] {IDLE, MERGE, SCAN, DONE} state_t;

    state_t         state_q, state_d;
    logic [143:0]   board_q, board_d;
    logic [3:0]     row_q, row_d;
    logic [3:0]     lines_q, lines_d;
    logic           over_q, over_d;

    logic [11:0]    full_rows;
    logic [143:0]   shifted;
    logic           unused_ok;

    assign unused_ok = currentSqs[144];

    // shifted is the board with the row at row_q removed and everything above it dropped by one.
    genvar gi;
    generate
        for (gi = 0; gi < 12; gi++) begin : g_rows
            assign full_rows[gi] = &board_q[gi*12 +: 12];
            if (gi == 0) begin : g_top
                assign shifted[11:0] = '0;
            end else begin : g_below
                localparam logic [3:0] ROW_IDX = 4'(gi);
                assign shifted[gi*12 +: 12] = (ROW_IDX <= row_q) ? board_q[(gi-1)*12 +: 12]
                                                                 : board_q[gi*12 +: 12];
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        row_d   = row_q;
        lines_d = lines_q;
        over_d  = over_q;
        case (state_q)
            IDLE: begin
                if (lock) begin
                    state_d = MERGE;
                    lines_d = 4'd0;
                end
            end
            MERGE: begin
                board_d = board_q | currentSqs[143:0];
                row_d   = 4'd11;
                state_d = SCAN;
            end
            SCAN: begin
                // Row pointer stays put after a clear so the row that dropped in is re-tested.
                if (full_rows[row_q]) begin
                    board_d = shifted;
                    lines_d = lines_q + 4'd1;
                end else if (row_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    row_d = row_q - 4'd1;
                end
            end
            DONE: begin
                if (|board_q[11:0]) over_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            board_q <= '0;
            row_q   <= 4'd11;
            lines_q <= 4'd0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            row_q   <= row_d;
            lines_q <= lines_d;
            over_q  <= over_d;
        end
    end

    assign backGround    = {1'b0, board_q};
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign lines_cleared = lines_q;
    assign game_over     = over_q;

endmodule

// File: tb/tb_line_clear_unit.sv
// Directed bench for line_clear_unit: table of lock operations plus hand-written
// sequences for continuous lock and reset during a scan.
module tb_line_clear_unit;

    logic         clk;
    logic         reset;
    logic         lock;
    logic [144:0] currentSqs;
    logic [144:0] backGround;
    logic         busy;
    logic         done;
    logic [3:0]   lines_cleared;
    logic         game_over;

    int n_checks = 0;
    int n_fail   = 0;

    line_clear_unit dut (
        .clk           (clk),
        .reset         (reset),
        .lock          (lock),
        .currentSqs    (currentSqs),
        .backGround    (backGround),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .game_over     (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           rst;
        logic [143:0] piece;
        logic [143:0] exp_board;
        logic [3:0]   exp_lines;
        int           exp_busy;
        logic         exp_over;
    } vec_t;

    vec_t         vecs[7];
    logic [143:0] board_m;

    function automatic logic [143:0] rng(int lo, int hi);
        logic [143:0] v;
        v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [144:0] act, input logic [144:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_board", backGround, '0);
        chk("reset_busy", 145'(busy), 145'(0));
        chk("reset_done", 145'(done), 145'(0));
        chk("reset_lines", 145'(lines_cleared), 145'(0));
        chk("reset_over", 145'(game_over), 145'(0));
        board_m = '0;
    endtask

    task automatic run_vec(input int idx);
        int cnt;
        if (vecs[idx].rst) do_reset();
        @(negedge clk);
        currentSqs = {1'b0, vecs[idx].piece};
        lock = 1'b1;
        @(negedge clk);
        lock = 1'b0;
        cnt = 1;
        chk("merge_busy", 145'(busy), 145'(1));
        chk("merge_board_old", backGround, {1'b0, board_m});
        @(negedge clk);
        cnt = 2;
        chk("merged_board", backGround, {1'b0, board_m | vecs[idx].piece});
        while (!done && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        chk("busy_cycles", 145'(cnt), 145'(vecs[idx].exp_busy));
        @(negedge clk);
        chk("idle_busy", 145'(busy), 145'(0));
        chk("idle_done", 145'(done), 145'(0));
        chk("final_board", backGround, {1'b0, vecs[idx].exp_board});
        chk("lines", 145'(lines_cleared), 145'(vecs[idx].exp_lines));
        chk("game_over", 145'(game_over), 145'(vecs[idx].exp_over));
        $display("vec %0d: busy=%0d lines=%0d over=%0b", idx, cnt, lines_cleared, game_over);
        board_m = vecs[idx].exp_board;
    endtask

    initial begin
        int idle_cnt;
        int done_cnt;
        int first_done;
        int guard;

        reset = 1'b1;
        lock = 1'b0;
        currentSqs = '0;
        board_m = '0;

        vecs[0] = '{1'b1, rng(132, 135), rng(132, 135), 4'd0, 14, 1'b0};
        vecs[1] = '{1'b1, rng(132, 139) | rng(120, 120), rng(132, 139) | rng(120, 120), 4'd0, 14, 1'b0};
        vecs[2] = '{1'b0, rng(140, 143), rng(132, 132), 4'd1, 15, 1'b0};
        vecs[3] = '{1'b1, rng(132, 143) | rng(108, 119) | rng(125, 125), rng(137, 137), 4'd2, 16, 1'b0};
        vecs[4] = '{1'b1, rng(0, 143), '0, 4'd12, 26, 1'b0};
        vecs[5] = '{1'b1, rng(3, 3), rng(3, 3), 4'd0, 14, 1'b1};
        vecs[6] = '{1'b0, rng(143, 143), rng(3, 3) | rng(143, 143), 4'd0, 14, 1'b1};

        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(i);

        // Reset during SCAN with game_over already set and a clear in progress.
        @(negedge clk);
        currentSqs = {1'b0, rng(132, 143)};
        lock = 1'b1;
        @(negedge clk);
        lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midscan_lines", 145'(lines_cleared), 145'(1));
        chk("midscan_busy", 145'(busy), 145'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midscan_rst_board", backGround, '0);
        chk("midscan_rst_busy", 145'(busy), 145'(0));
        chk("midscan_rst_lines", 145'(lines_cleared), 145'(0));
        chk("midscan_rst_over", 145'(game_over), 145'(0));
        $display("midscan reset: board=%h busy=%0b", backGround, busy);
        board_m = '0;

        // lock held high: one operation per IDLE entry, one idle cycle between.
        @(negedge clk);
        currentSqs = {1'b0, rng(60, 60)};
        lock = 1'b1;
        idle_cnt = 0;
        done_cnt = 0;
        first_done = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) idle_cnt++;
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = i;
            end
        end
        lock = 1'b0;
        guard = 0;
        while (busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("hold_idle_cycles", 145'(idle_cnt), 145'(2));
        chk("hold_done_pulses", 145'(done_cnt), 145'(2));
        chk("hold_first_done", 145'(first_done), 145'(13));
        chk("hold_busy_end", 145'(busy), 145'(0));
        chk("hold_board", backGround, {1'b0, rng(60, 60)});
        chk("hold_lines", 145'(lines_cleared), 145'(0));
        $display("lock held: idle=%0d done=%0d first_done=%0d", idle_cnt, done_cnt, first_done);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_clear_unit.md
# line_clear_unit

Writes the landed piece into the 12x12 Tetris playfield and removes completed rows. It sits downstream of the bottom-collision detector. When that detector reports a landing, this block ORs the falling piece into the background, then scans the board one row per cycle, shifting rows down over every full row. It also reports how many lines were cleared and whether the stack has topped out.

## Interface
Parameters: none. Grid fixed at 12 columns x 12 rows; vectors are 145 bits, bit 144 unused.
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clears board, counters, flags, FSM to IDLE
- lock  input  1  landing request (driven by hasReachedBottom); sampled only in IDLE
- currentSqs  input  145  falling-piece occupancy, same cell map as backGround
- backGround  output  145  registered playfield occupancy
- busy  output  1  high in MERGE, SCAN, DONE
- done  output  1  one-cycle pulse in DONE state
- lines_cleared  output  4  rows removed by the last lock operation
- game_over  output  1  sticky top-out flag

## Operation
- Cell map: bit i is row i/12 and column i%12. Row 0 is the top and row 11 the bottom; the cell below bit i is bit i+12. Bit 144 of backGround is always 0.
- FSM states: IDLE, MERGE, SCAN, DONE.
- IDLE: if lock=1, go to MERGE and clear lines_cleared to 0. Otherwise hold.
- MERGE (1 cycle): backGround[143:0] <= backGround[143:0] | currentSqs[143:0]. Overlapping cells simply stay 1. Row pointer r <= 11. Go to SCAN.
- SCAN, row r full (all 12 bits set):
  - row k <= row k-1 for k = r down to 1; row 0 <= 0.
  - lines_cleared += 1.
  - r is unchanged, so the shifted-in row is re-checked next cycle.
- SCAN, row r not full: if r = 0, go to DONE; otherwise r <= r-1.
- DONE (1 cycle): done=1. If row 0 has any bit set, game_over <= 1. Go to IDLE.
- lines_cleared holds its value until the next accepted lock. Range is 0..12, with no saturation needed.
- game_over stays 1 until reset. Further locks are still processed normally.
- lock asserted while busy=1 is ignored and not queued.
- currentSqs is sampled only in MERGE. Upstream must keep it stable during that cycle.

## Timing
- Reset values: backGround=0, busy=0, done=0, lines_cleared=0, game_over=0, state IDLE, r=11.
- Reset asserted in any state takes effect at that edge. Any partial merge or shift in progress is discarded and the board reads 0 on the next cycle.
- lock sampled high at edge N puts the FSM in MERGE for cycle N+1. The merged board is visible after edge N+1.
- SCAN takes 12+k cycles, where k = rows cleared. Total busy time is 14+k cycles: MERGE + SCAN + DONE.
- done is high exactly in cycle N+14+k.
- The earliest next lock is accepted at the first IDLE edge after DONE.
- Board updates from SCAN are visible on the cycle after each shift decision. Intermediate board states are not guaranteed to be stable game frames; consumers should use done.

## Test plan
- Empty board, piece on row 11 columns 0-3, no full row:
  - bits 132-135 set after MERGE;
  - done after 14 busy cycles;
  - lines_cleared=0.
- Row 11 columns 0-7 in background, piece fills columns 8-11, row 10 column 0 set:
  - after done, row 11 = only column 0, row 10 empty;
  - lines_cleared=1;
  - busy for 15 cycles.
- Rows 11 and 9 become full, row 10 holds a single cell at column 5:
  - result is that cell at bit 137 (row 11, column 5), all other bits 0;
  - lines_cleared=2.
- All 144 cells set after merge:
  - board all zeros;
  - lines_cleared=12;
  - busy 26 cycles;
  - game_over=0.
- lock held high continuously: exactly one operation per IDLE entry, no lock accepted while busy.
- Reset asserted mid-SCAN:
  - next cycle backGround=0, busy=0, lines_cleared=0, game_over=0.
- Merge leaves column 3 of row 0 set with no clears: game_over=1 in the cycle after done, and it persists.
